// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: nibble-serial multi-precision add/subtract sequencer.
// Latches two W-bit operands (W = 4*NIBBLES) on start and pushes them one
// nibble per clock, LSB first, through a single 4-bit adder slice. A carry
// register chains the nibbles. The result, carry and signed overflow are
// reported together with a one-cycle done pulse.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      operation request, honoured in IDLE or DONE only
//   sub        0 = a+b, 1 = a-b (latched with the operands)
//   a, b       W-bit operands
//   busy       high while nibbles are being processed
//   done       one-cycle pulse; result/carry_out/overflow valid from here on
//   result     W-bit sum/difference, held until the next accept
//   carry_out  carry out of the MSB nibble (subtract: 1 = no borrow)
//   overflow   two's-complement overflow of the full-width operation

// addition: 4-bit adder slice.
// Ports: a, b, carry_in -> y, carry_out, overflow (carry into bit 3 ^ carry out).
module addition (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       carry_in,
  output logic [3:0] y,
  output logic       carry_out,
  output logic       overflow
);
  logic [4:0] sum;

  assign sum       = {1'b0, a} + {1'b0, b} + {4'b0000, carry_in};
  assign y         = sum[3:0];
  assign carry_out = sum[4];
  // The carry into bit 3 is recovered from that bit's sum: a3 ^ b3 ^ y3.
  assign overflow  = (a[3] ^ b[3] ^ sum[3]) ^ sum[4];
endmodule

// state | meaning
// IDLE  | waiting for start
// RUN   | processing nibble idx (0..NIBBLES-1)
// DONE  | one cycle, result valid, done asserted
module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   overflow
);
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         idx;
  logic [NIBBLES-1:0][3:0]  a_q, b_q, res_q;
  logic                     sub_q, carry_q;
  logic                     accept, last;
  logic [3:0]               slice_b, slice_y;
  logic                     slice_co, slice_ov;

  assign accept  = start && (state == IDLE || state == DONE);
  assign last    = (idx == IDX_W'(NIBBLES - 1));
  // Subtraction as a + ~b + 1: the +1 enters through the carry register on accept.
  assign slice_b = sub_q ? ~b_q[idx] : b_q[idx];

  addition u_slice (
    .a         (a_q[idx]),
    .b         (slice_b),
    .carry_in  (carry_q),
    .y         (slice_y),
    .carry_out (slice_co),
    .overflow  (slice_ov)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      carry_q   <= 1'b0;
      sub_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_q       <= a;
      b_q       <= b;
      sub_q     <= sub;
      idx       <= '0;
      carry_q   <= sub;
      res_q     <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == RUN) begin
      res_q[idx] <= slice_y;
      carry_q    <= slice_co;
      idx        <= last ? '0 : idx + 1'b1;
      if (last) begin
        carry_out <= slice_co;
        overflow  <= slice_ov;
      end
    end
  end

  assign busy   = (state == RUN);
  assign done   = (state == DONE);
  assign result = res_q;
endmodule
